// File: rtl/dit_lockstep_timing_monitor.sv
// Lockstep timing monitor for data-independent-timing checks of a two-copy
// miter. One transaction is tracked at a time. Both copies' latencies are
// measured from the shared accept to each out_valid. A sticky leak flag is
// raised when a secret-sensitive op class shows diverging latencies.
//
// Optional feature macro: DIT_MON_ASSERT_EN
//   defined   -> concurrent assertions on the sticky flags, plus a cover of
//                done_o for every checked op
//   undefined -> flags are the only reporting path
//
// Results (lat*_o, last_op_o, counters, flags) are registered on the edge
// that enters REPORT, so they are already valid while done_o is high.
module dit_lockstep_timing_monitor #(
  parameter int              OP_W     = 4,
  parameter int              MAX_LAT  = 64,
  parameter logic [15:0]     SEC_MASK = 16'h01F8,
  parameter int              CNT_W    = 16,
  localparam int             CW       = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             in_valid_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             out_valid1_i,
  input  logic             out_valid2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    lat1_o,
  output logic [CW-1:0]    lat2_o,
  output logic [OP_W-1:0]  last_op_o,
  output logic             leak_o,
  output logic [OP_W-1:0]  leak_op_o,
  output logic             timeout_o,
  output logic             proto_err_o,
  output logic [CNT_W-1:0] txn_cnt_o,
  output logic [CNT_W-1:0] leak_cnt_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_LAT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BOTH = 3'd1,
    WAIT2     = 3'd2,  // copy 1 finished, copy 2 pending
    WAIT1     = 3'd3,  // copy 2 finished, copy 1 pending
    REPORT    = 3'd4
  } state_e;

  state_e          st_q, st_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   lat1_w, lat2_w;   // latencies of copies already finished
  logic [OP_W-1:0] op_q;

  logic            accept, go_rep, tmo_ev, perr_ev, ld1, ld2;
  logic [CW-1:0]   f1, f2;           // final latencies on the REPORT entry edge
  logic            at_max, op_chk, leak_ev;

  assign at_max = (cnt_q == MAX_C);

  // Ops outside the mask width are never timing-checked.
  function automatic logic sec_checked(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 16; k++)
      if (int'(op) == k) r = SEC_MASK[k];
    return r;
  endfunction

  assign op_chk  = sec_checked(op_q);
  assign leak_ev = go_rep && op_chk && (f1 != f2);

  // Next-state logic plus per-cycle latency capture and event decode
  always_comb begin
    st_d    = st_q;
    accept  = 1'b0;
    go_rep  = 1'b0;
    tmo_ev  = 1'b0;
    perr_ev = 1'b0;
    ld1     = 1'b0;
    ld2     = 1'b0;
    f1      = lat1_w;
    f2      = lat2_w;
    case (st_q)
      IDLE: begin
        if (in_valid_i) begin
          accept = 1'b1;
          st_d   = WAIT_BOTH;
        end
        if (out_valid1_i || out_valid2_i) perr_ev = 1'b1;
      end
      WAIT_BOTH: begin
        if (out_valid1_i && out_valid2_i) begin
          f1     = cnt_q;
          f2     = cnt_q;
          go_rep = 1'b1;
        end else if (out_valid1_i) begin
          f1  = cnt_q;
          ld1 = 1'b1;
          if (at_max) begin
            f2     = MAX_C;
            tmo_ev = 1'b1;
            go_rep = 1'b1;
          end else begin
            st_d = WAIT2;
          end
        end else if (out_valid2_i) begin
          f2  = cnt_q;
          ld2 = 1'b1;
          if (at_max) begin
            f1     = MAX_C;
            tmo_ev = 1'b1;
            go_rep = 1'b1;
          end else begin
            st_d = WAIT1;
          end
        end else if (at_max) begin
          f1     = MAX_C;
          f2     = MAX_C;
          tmo_ev = 1'b1;
          go_rep = 1'b1;
        end
      end
      WAIT2: begin
        if (out_valid1_i) perr_ev = 1'b1;  // repeat of a finished copy, ignored
        if (out_valid2_i) begin
          f2     = cnt_q;
          go_rep = 1'b1;
        end else if (at_max) begin
          f2     = MAX_C;
          tmo_ev = 1'b1;
          go_rep = 1'b1;
        end
      end
      WAIT1: begin
        if (out_valid2_i) perr_ev = 1'b1;
        if (out_valid1_i) begin
          f1     = cnt_q;
          go_rep = 1'b1;
        end else if (at_max) begin
          f1     = MAX_C;
          tmo_ev = 1'b1;
          go_rep = 1'b1;
        end
      end
      REPORT: begin
        st_d = IDLE;
        // Both copies already closed, so any result valid here is orphaned.
        if (out_valid1_i || out_valid2_i) perr_ev = 1'b1;
      end
      default: st_d = IDLE;
    endcase
    // A request while anything is open is dropped; tracking continues.
    if (in_valid_i && st_q != IDLE) perr_ev = 1'b1;
    if (go_rep) st_d = REPORT;
  end

  assign busy_o = (st_q != IDLE);
  assign done_o = (st_q == REPORT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // Latency counter, op latch and per-copy working latencies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lat1_w <= '0;
      lat2_w <= '0;
      op_q   <= '0;
    end else begin
      if (accept) begin
        // First cycle after accept reads as latency 1.
        cnt_q  <= CW'(1);
        lat1_w <= '0;
        lat2_w <= '0;
        op_q   <= op_i;
      end else if ((st_q == WAIT_BOTH || st_q == WAIT1 || st_q == WAIT2) && !go_rep) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (ld1) lat1_w <= cnt_q;
      if (ld2) lat2_w <= cnt_q;
    end
  end

  // Report registers; untouched by clr_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat1_o    <= '0;
      lat2_o    <= '0;
      last_op_o <= '0;
    end else if (go_rep) begin
      lat1_o    <= f1;
      lat2_o    <= f2;
      last_op_o <= op_q;
    end
  end

  // Sticky flags; a same-cycle event beats clr_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leak_o      <= 1'b0;
      timeout_o   <= 1'b0;
      proto_err_o <= 1'b0;
      leak_op_o   <= '0;
    end else begin
      if (leak_ev)     leak_o <= 1'b1;
      else if (clr_i)  leak_o <= 1'b0;
      if (tmo_ev)      timeout_o <= 1'b1;
      else if (clr_i)  timeout_o <= 1'b0;
      if (perr_ev)     proto_err_o <= 1'b1;
      else if (clr_i)  proto_err_o <= 1'b0;
      // Only the first leak since reset/clear is remembered.
      if (leak_ev && (!leak_o || clr_i)) leak_op_o <= op_q;
      else if (clr_i)                    leak_op_o <= '0;
    end
  end

  // Saturating transaction counters; a same-cycle event after clr_i reads 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_o  <= '0;
      leak_cnt_o <= '0;
    end else begin
      if (go_rep) begin
        if (clr_i)            txn_cnt_o <= CNT_W'(1);
        else if (~&txn_cnt_o) txn_cnt_o <= txn_cnt_o + CNT_W'(1);
      end else if (clr_i) begin
        txn_cnt_o <= '0;
      end
      if (leak_ev) begin
        if (clr_i)             leak_cnt_o <= CNT_W'(1);
        else if (~&leak_cnt_o) leak_cnt_o <= leak_cnt_o + CNT_W'(1);
      end else if (clr_i) begin
        leak_cnt_o <= '0;
      end
    end
  end

`ifdef DIT_MON_ASSERT_EN
  a_no_leak:  assert property (@(posedge clk) disable iff (!rst_n) !leak_o);
  a_no_tmo:   assert property (@(posedge clk) disable iff (!rst_n) !timeout_o);
  a_no_proto: assert property (@(posedge clk) disable iff (!rst_n) !proto_err_o);

  for (genvar k = 0; k < 16; k++) begin : g_cov
    if (SEC_MASK[k] && (k < (1 << OP_W))) begin : g_chk
      c_done: cover property (@(posedge clk) disable iff (!rst_n)
                              done_o && (int'(last_op_o) == k));
    end
  end
`endif

endmodule

// File: tb/tb_dit_lockstep_timing_monitor.sv
// Directed bench for dit_lockstep_timing_monitor: latency measurement,
// leak detection, timeout, protocol errors, clear priority and async reset.
module tb_dit_lockstep_timing_monitor;

  localparam int OP_W    = 4;
  localparam int MAX_LAT = 64;
  localparam int CNT_W   = 16;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic             clk = 1'b0;
  logic             rst_n, clr_i, in_valid_i, out_valid1_i, out_valid2_i;
  logic [OP_W-1:0]  op_i;
  logic             busy_o, done_o, leak_o, timeout_o, proto_err_o;
  logic [CW-1:0]    lat1_o, lat2_o;
  logic [OP_W-1:0]  last_op_o, leak_op_o;
  logic [CNT_W-1:0] txn_cnt_o, leak_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;
  int done_at;

  dit_lockstep_timing_monitor #(
    .OP_W(OP_W), .MAX_LAT(MAX_LAT), .SEC_MASK(16'h01F8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .in_valid_i(in_valid_i),
    .op_i(op_i), .out_valid1_i(out_valid1_i), .out_valid2_i(out_valid2_i),
    .busy_o(busy_o), .done_o(done_o), .lat1_o(lat1_o), .lat2_o(lat2_o),
    .last_op_o(last_op_o), .leak_o(leak_o), .leak_op_o(leak_op_o),
    .timeout_o(timeout_o), .proto_err_o(proto_err_o),
    .txn_cnt_o(txn_cnt_o), .leak_cnt_o(leak_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept op, then walk cycles +1.. driving v1 at t1, v2 at t2 (0 = never),
  // a stray in_valid at dup and clr_i at clr_at. done_at = cycle of done_o.
  task automatic run_txn(input logic [OP_W-1:0] op, input int t1, input int t2,
                         input int dup, input int clr_at, output int d_at);
    in_valid_i = 1'b1;
    op_i       = op;
    tick();
    in_valid_i = 1'b0;
    d_at = -1;
    for (int c = 1; c <= MAX_LAT + 4; c++) begin
      out_valid1_i = (c == t1);
      out_valid2_i = (c == t2);
      in_valid_i   = (c == dup);
      clr_i        = (c == clr_at);
      tick();
      out_valid1_i = 1'b0;
      out_valid2_i = 1'b0;
      in_valid_i   = 1'b0;
      clr_i        = 1'b0;
      if (done_o) begin
        d_at = c + 1;
        break;
      end
    end
    if (d_at < 0) chk("txn_timeout_bound", 32'(d_at), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr_i = 1'b0; in_valid_i = 1'b0; op_i = '0;
    out_valid1_i = 1'b0; out_valid2_i = 1'b0;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_txn", txn_cnt_o, 0);
    chk("rst_leak", leak_o, 0);
    rst_n = 1'b1;
    tick();

    // 1: matched latency on a checked op
    run_txn(4'd3, 5, 5, 0, 0, done_at);
    chk("t1_done_at", done_at, 6);
    chk("t1_lat1", lat1_o, 5);
    chk("t1_lat2", lat2_o, 5);
    chk("t1_leak", leak_o, 0);
    chk("t1_txn", txn_cnt_o, 1);
    chk("t1_last_op", last_op_o, 3);
    tick();
    chk("t1_idle", busy_o, 0);

    // 2: diverging latency on a checked op
    run_txn(4'd7, 3, 34, 0, 0, done_at);
    chk("t2_done_at", done_at, 35);
    chk("t2_lat1", lat1_o, 3);
    chk("t2_lat2", lat2_o, 34);
    chk("t2_leak", leak_o, 1);
    chk("t2_leak_op", leak_op_o, 7);
    chk("t2_leak_cnt", leak_cnt_o, 1);
    chk("t2_txn", txn_cnt_o, 2);
    tick();
    pulse_clr();
    chk("clr_leak", leak_o, 0);
    chk("clr_leak_op", leak_op_o, 0);
    chk("clr_txn", txn_cnt_o, 0);
    chk("clr_leak_cnt", leak_cnt_o, 0);
    chk("clr_keeps_lat2", lat2_o, 34);

    // 3: unchecked op, minimum latency 1
    run_txn(4'd0, 1, 32, 0, 0, done_at);
    chk("t3_done_at", done_at, 33);
    chk("t3_lat1", lat1_o, 1);
    chk("t3_lat2", lat2_o, 32);
    chk("t3_leak", leak_o, 0);
    chk("t3_txn", txn_cnt_o, 1);
    tick();

    // 4: copy 2 never answers -> timeout at MAX_LAT
    run_txn(4'd8, 2, 0, 0, 0, done_at);
    chk("t4_done_at", done_at, 65);
    chk("t4_lat1", lat1_o, 2);
    chk("t4_lat2", lat2_o, 64);
    chk("t4_timeout", timeout_o, 1);
    chk("t4_leak", leak_o, 1);
    chk("t4_leak_op", leak_op_o, 8);
    chk("t4_txn", txn_cnt_o, 2);
    tick();
    pulse_clr();
    chk("clr_timeout", timeout_o, 0);

    // 5: protocol errors: result valid in IDLE, request while busy
    out_valid1_i = 1'b1;
    tick();
    out_valid1_i = 1'b0;
    chk("t5_idle_valid_perr", proto_err_o, 1);
    chk("t5_idle_no_txn", txn_cnt_o, 0);
    pulse_clr();
    chk("t5_clr_perr", proto_err_o, 0);
    run_txn(4'd4, 4, 4, 2, 0, done_at);
    chk("t5_done_at", done_at, 5);
    chk("t5_busy_perr", proto_err_o, 1);
    chk("t5_txn", txn_cnt_o, 1);
    tick();
    chk("t5_no_extra_accept", busy_o, 0);

    // 6: async reset mid-transaction
    in_valid_i = 1'b1; op_i = 4'd5;
    tick();
    in_valid_i = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_txn", txn_cnt_o, 0);
    chk("t6_rst_lat2", lat2_o, 0);
    chk("t6_rst_perr", proto_err_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // Build up one leak, then clear in the same cycle as a second leak.
    run_txn(4'd3, 1, 2, 0, 0, done_at);
    chk("t6_pre_leak_cnt", leak_cnt_o, 1);
    tick();
    run_txn(4'd6, 1, 3, 0, 3, done_at);
    chk("t6_clr_leak", leak_o, 1);
    chk("t6_clr_leak_cnt", leak_cnt_o, 1);
    chk("t6_clr_txn", txn_cnt_o, 1);
    chk("t6_clr_leak_op", leak_op_o, 6);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
